// File: rtl/led_array_scanner.sv
// led_array_scanner: column sequencer and frame double-buffer for led_array_driver.
// Latency: IDLE->scan one cycle after run is sampled; a loaded frame shows at the next frame boundary.
// Backpressure: frame_ready = !pending_full, so one frame is held until the swap frees the buffer.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   run                 enable scanning; checked at each column end (and in IDLE)
//   frame_in/_valid     new N*N image with its valid strobe (bit N*j+i = LED (i,j))
//   frame_ready         pending buffer empty, a frame can be taken this cycle
//   cells, x, ena       displayed image, column index and enable for the driver
//   frame_done          one-cycle pulse in the first cycle after column N-1 finishes
//
// Option: define LED_SCANNER_BLANK_EN to add a blanking interval of BLANK_CYCLES with
// ena=0 before each column. Without it, ena stays high while scanning and x steps
// directly between dwell periods.
module led_array_scanner #(
    parameter int N            = 5,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic [N*N-1:0]         frame_in,
    input  logic                   frame_valid,
    output logic                   frame_ready,
    output logic [N*N-1:0]         cells,
    output logic [$clog2(N):0]     x,
    output logic                   ena,
    output logic                   frame_done
);

    localparam int MAXC  = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);
    localparam int XW    = $clog2(N) + 1;

    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES - 1);
`ifdef LED_SCANNER_BLANK_EN
    localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES - 1);
`endif
    localparam logic [XW-1:0]    X_LAST   = XW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [N*N-1:0]   pending;
    logic             pending_full;

    // Purely a function of registered state, so no path from frame_valid.
    assign frame_ready = !pending_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            x            <= '0;
            ena          <= 1'b0;
            cells        <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // Load and swap are mutually exclusive: a load needs pending_full=0,
            // a swap needs pending_full=1, so the two never fight over the flag.
            if (frame_valid && !pending_full) begin
                pending      <= frame_in;
                pending_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (run) begin
`ifdef LED_SCANNER_BLANK_EN
                        state <= BLANK;
                        cnt   <= BLANK_LD;
`else
                        state <= DRIVE;
                        cnt   <= DWELL_LD;
                        ena   <= 1'b1;
`endif
                    end
                end

`ifdef LED_SCANNER_BLANK_EN
                BLANK: begin
                    if (cnt == '0) begin
                        state <= DRIVE;
                        cnt   <= DWELL_LD;
                        ena   <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
`endif

                DRIVE: begin
                    if (cnt == '0) begin
                        // End of column: x is only ever written here, i.e. at the
                        // moment the driver is about to be blanked or stopped.
                        if (x == X_LAST) begin
                            frame_done <= 1'b1;
                            if (pending_full) begin
                                cells        <= pending;
                                pending_full <= 1'b0;
                            end
                        end
                        if (run) begin
                            x <= (x == X_LAST) ? '0 : x + XW'(1);
`ifdef LED_SCANNER_BLANK_EN
                            state <= BLANK;
                            cnt   <= BLANK_LD;
                            ena   <= 1'b0;
`else
                            cnt   <= DWELL_LD;
`endif
                        end else begin
                            // Stopping always parks on column 0 so a restart
                            // begins a fresh frame.
                            x     <= '0;
                            state <= IDLE;
                            ena   <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    ena   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_array_scanner.sv
module tb_led_array_scanner;

    localparam int N     = 4;
    localparam int DWELL = 3;
    localparam int BLANK = 2;
`ifdef LED_SCANNER_BLANK_EN
    localparam int B_EFF = BLANK;
`else
    localparam int B_EFF = 0;
`endif
    localparam int PERIOD = B_EFF + DWELL;   // column period in cycles

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  run = 1'b0;
    logic [N*N-1:0]        frame_in = '0;
    logic                  frame_valid = 1'b0;
    logic                  frame_ready;
    logic [N*N-1:0]        cells;
    logic [$clog2(N):0]    x;
    logic                  ena;
    logic                  frame_done;

    led_array_scanner #(.N(N), .DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .cells       (cells),
        .x           (x),
        .ena         (ena),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Scanning is described by a phase t within the column period: the first
    // B_EFF phases are blanked, the rest drive. A column ends when t reaches
    // PERIOD-1; the frame ends when that column is the last one.
    logic            m_act = 1'b0;
    int              m_t   = 0;
    int              m_col = 0;
    logic [N*N-1:0]  m_cells = '0;
    logic [N*N-1:0]  m_pend  = '0;
    logic            m_pfull = 1'b0;
    logic            m_done  = 1'b0;
    logic            chk_en  = 1'b0;

    always @(posedge clk) begin : model
        logic           act, pf, d;
        int             t, col;
        logic [N*N-1:0] c, p;
        act = m_act; t = m_t; col = m_col; c = m_cells; p = m_pend; pf = m_pfull; d = 1'b0;
        if (rst) begin
            act = 1'b0; t = 0; col = 0; c = '0; p = '0; pf = 1'b0;
        end else begin
            if (!act) begin
                if (run) begin
                    act = 1'b1;
                    t   = 0;
                end
            end else if (t == PERIOD - 1) begin
                if (col == N - 1) begin
                    d = 1'b1;
                    if (m_pfull) begin
                        c  = m_pend;
                        pf = 1'b0;
                    end
                end
                if (run) col = (col + 1) % N;
                else begin
                    col = 0;
                    act = 1'b0;
                end
                t = 0;
            end else begin
                t = t + 1;
            end
            if (frame_valid && !m_pfull) begin
                p  = frame_in;
                pf = 1'b1;
            end
        end
        m_act <= act; m_t <= t; m_col <= col; m_cells <= c; m_pend <= p;
        m_pfull <= pf; m_done <= d;
        if (rst) chk_en <= 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ena",         {31'd0, ena},         {31'd0, (m_act && m_t >= B_EFF)});
            check("x",           {29'd0, x},           m_col);
            check("cells",       {16'd0, cells},       {16'd0, m_cells});
            check("frame_ready", {31'd0, frame_ready}, {31'd0, !m_pfull});
            check("frame_done",  {31'd0, frame_done},  {31'd0, m_done});
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sel: 0 frame_done, 1 column 1 driving, 2 column 2 driving, 3 ena high
    task automatic wait_for(input int sel, input int lim, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            tick();
            if ((sel == 0 && frame_done) || (sel == 1 && x == 1 && ena) ||
                (sel == 2 && x == 2 && ena) || (sel == 3 && ena)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout(name);
    endtask

    initial begin
        int             cyc;
        bit             seen;
        logic [N*N-1:0] c0;

        // Reset
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_ena",   {31'd0, ena}, 0);
        check("rst_x",     {29'd0, x}, 0);
        check("rst_cells", {16'd0, cells}, 0);
        check("rst_ready", {31'd0, frame_ready}, 1);
        check("rst_done",  {31'd0, frame_done}, 0);

        // Scan sequence and frame period
        run = 1'b1;
        wait_for(0, 200, "first_done");
        cyc = 0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            cyc++;
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) timeout("second_done");
`ifdef LED_SCANNER_BLANK_EN
        check("frame_period", cyc, 20);
`else
        check("frame_period", cyc, 12);
`endif

        // Double buffer
        tick(); tick(); tick();
        c0 = cells;
        frame_in = 16'h0001; frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        check("db_ready_low", {31'd0, frame_ready}, 0);
        check("db_cells_hold", {16'd0, cells}, {16'd0, c0});
        wait_for(0, 200, "db_done1");
        check("db_cells_swap", {16'd0, cells}, 32'h0001);
        check("db_ready_high", {31'd0, frame_ready}, 1);
        frame_in = 16'h8000; frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        check("db_second_pending", {31'd0, frame_ready}, 0);
        check("db_second_hidden", {16'd0, cells}, 32'h0001);
        wait_for(0, 200, "db_done2");
        check("db_second_swap", {16'd0, cells}, 32'h8000);

        // Stop during column 1
        wait_for(1, 200, "stop_col1");
        run = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (frame_done) seen = 1'b1;
        end
        check("stop_ena", {31'd0, ena}, 0);
        check("stop_x", {29'd0, x}, 0);
        check("stop_no_done", {31'd0, seen}, 0);
        check("stop_cells_kept", {16'd0, cells}, 32'h8000);
        run = 1'b1;
        wait_for(3, 20, "restart");
        check("restart_col0", {29'd0, x}, 0);

        // Mid-operation reset with a pending frame
        wait_for(0, 200, "mr_done");
        frame_in = 16'h5a5a; frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        check("mr_pending_full", {31'd0, frame_ready}, 0);
        wait_for(2, 200, "mr_col2");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_ena",   {31'd0, ena}, 0);
        check("mr_x",     {29'd0, x}, 0);
        check("mr_cells", {16'd0, cells}, 0);
        check("mr_ready", {31'd0, frame_ready}, 1);
        check("mr_done",  {31'd0, frame_done}, 0);
        wait_for(0, 200, "mr_next_done");
        check("mr_pending_discarded", {16'd0, cells}, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            run         = ($urandom_range(0, 19) != 0);
            frame_valid = ($urandom_range(0, 2) == 0);
            frame_in    = N*N'($urandom);
            rst         = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        frame_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_array_scanner.md
# led_array_scanner

Sequencing controller for `led_array_driver`. It steps the driver's column index `x` through `0..N-1`, holding each column for a programmable dwell time, and gates `ena` so that `x` changes only while the array is blanked. It double-buffers the N×N cell image so that a new frame from the game-of-life core takes effect only at a frame boundary. It sits between the game-of-life state register and `led_array_driver`.

## Interface
Parameters:
- `N`, 5: array dimension; must match the `N`/`ROWS`/`COLS` of the driven `led_array_driver`.
- `DWELL_CYCLES`, 1000: clock cycles each column is driven (`ena`=1); must be ≥1.
- `BLANK_CYCLES`, 2: clock cycles of `ena`=0 before each column; must be ≥1. Used only when the blanking feature is compiled in.

Ports:
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  enables scanning; sampled as described in Operation.
- `frame_in`  in  N*N  new cell image; bit `N*j+i` is LED (i, j).
- `frame_valid`  in  1  `frame_in` is valid this cycle.
- `frame_ready`  out  1  pending buffer is empty and can accept a frame.
- `cells`  out  N*N  displayed image; connects to driver `cells`.
- `x`  out  $clog2(N)+1  current column; connects to driver `x`.
- `ena`  out  1  connects to driver `ena`.
- `frame_done`  out  1  one-cycle pulse at each frame boundary.

## Operation
- State machine with states IDLE, BLANK and DRIVE. A down-counter `cnt` is sized `$clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1)`.
- **IDLE:** `ena`=0 and `x`=0. If `run`=1, the next state is BLANK with `cnt`=BLANK_CYCLES-1.
- **BLANK:** `ena`=0. Decrement `cnt`. At `cnt`=0, go to DRIVE with `cnt`=DWELL_CYCLES-1. `run` is ignored in this state.
- **DRIVE:** `ena`=1. Decrement `cnt`. At `cnt`=0 (end of column):
  - If `x`<N-1: `x`←`x`+1.
  - Otherwise: `x`←0 (wrap), pulse `frame_done`, and perform the buffer swap.
  - Then, if `run`=1, go to BLANK with `cnt` reloaded; if `run`=0, go to IDLE.
- `x` is only ever written on the DRIVE→BLANK/IDLE transition, so `x` never changes while `ena`=1 (when blanking is enabled).
- **Load handshake:** a transfer occurs when `frame_valid && frame_ready`.
  - The transfer writes `pending` and sets `pending_full`.
  - `frame_ready` = !`pending_full`, and is registered-state derived (no combinational path from `frame_valid`).
- **Swap:** at a frame boundary with `pending_full`=1: `cells`←`pending` and `pending_full`←0. If `pending_full`=0, `cells` holds its value.
- **Simultaneous load and boundary with `pending` empty:** the load goes to `pending` only. It is displayed at the next boundary.
- **Multiple loads before a boundary:** impossible, because `frame_ready` stays low until the swap.
- **`run` deasserted mid-frame:** the current column completes, then the block goes to IDLE and `x`=0. No `frame_done` pulse occurs unless that column was N-1. `cells` and `pending` are retained.
- **Loads while IDLE:** accepted into `pending`, then swapped in at the first completed frame.

## Timing
- Reset values: state=IDLE, `x`=0, `ena`=0, `cells`=0, `pending_full`=0, `frame_ready`=1, `frame_done`=0, `cnt`=0.
- `rst` asserted in any state forces the reset values on the next edge, including mid-column.
- IDLE→BLANK occurs one cycle after `run` is sampled high.
- Column period is BLANK_CYCLES+DWELL_CYCLES cycles. Frame period is N×(BLANK_CYCLES+DWELL_CYCLES).
- `frame_done` is high for exactly one cycle: the first cycle after the last DRIVE cycle of column N-1. The swapped `cells` value is visible in that same cycle.
- `frame_ready` rises in the same cycle as the `frame_done` that consumed `pending`.

## Configuration
- Macro: `LED_SCANNER_BLANK_EN`.
- **Defined:** BLANK state as described; `ena` drops for BLANK_CYCLES before each column.
- **Undefined:**
  - BLANK is removed. IDLE goes directly to DRIVE, and end-of-column reloads DRIVE.
  - `ena` stays 1 continuously while scanning; `x` changes on the cycle after the last dwell cycle.
  - Column period = DWELL_CYCLES. BLANK_CYCLES is unused.

## Test plan
All scenarios use N=4, DWELL_CYCLES=3, BLANK_CYCLES=2, with the macro defined unless stated otherwise.
- **Reset:** hold `rst` 2 cycles → `ena`=0, `x`=0, `cells`=0, `frame_ready`=1, `frame_done`=0.
- **Scan sequence:** `run`=1 → `ena` follows 0,0,1,1,1 per column. `x` steps 0,1,2,3,0 and changes only when `ena`=0. `frame_done` pulses every 20 cycles.
- **Double-buffer:** load 0x0001 mid-frame → `frame_ready`=0 and `cells` is unchanged until `frame_done`, when `cells`=0x0001 and `frame_ready`=1. A second load of 0x8000 in the boundary cycle appears only at the next `frame_done`.
- **Stop:** drop `run` during DRIVE of column 1 → the column completes, then IDLE with `x`=0, `ena`=0 and no `frame_done`. Reassert `run` → restarts at column 0.
- **Mid-operation reset:** assert `rst` during DRIVE of column 2 with `pending_full`=1 → all reset values on the next edge, and `pending` is discarded.
- **Macro undefined:** `ena` stays 1 while running, `x` advances every 3 cycles, and the frame period is 12 cycles.
